merge_n_handshake: RTL



---
 rtl/merge_n_handshake.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/merge_n_handshake.sv
// Merges N_CH four-phase req/ack producer channels onto one four-phase consumer port.
// The channel is picked by a decoder index (MODE=0) or round-robin (MODE=1) and held until its handshake returns to zero.
module merge_n_handshake #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32,
    parameter int SEL_W  = $clog2(N_CH),
    parameter int MODE   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     sel_valid,
    input  logic [N_CH-1:0]          req_in,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    output logic [N_CH-1:0]          ack_out,
    output logic                     req_out,
    output logic [DATA_W-1:0]        data_out,
    input  logic                     ack_in,
    output logic [SEL_W-1:0]         grant_idx,
    output logic                     busy,
    output logic                     sel_err
);

    typedef enum logic [1:0] {IDLE, FWD, HOLD, DRAIN} state_t;

    localparam int             N_IDX  = 1 << SEL_W;
    localparam logic [SEL_W:0] N_CH_W = (SEL_W+1)'(N_CH);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    g_q, g_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [N_CH-1:0]     ack_out_q, ack_out_d;
    logic                req_out_q, req_out_d;
    logic                sel_err_q, sel_err_d;
    logic                busy_q;

    logic [N_IDX-1:0]    req_ext;
    logic                sel_ok;
    logic                pick_hit;
    logic [SEL_W-1:0]    pick_idx;
    logic [DATA_W-1:0]   pick_data;
    logic                req_g;

    // Pad req_in to the full index range so an out-of-range sel reads 0.
    always_comb begin
        req_ext = '0;
        req_ext[N_CH-1:0] = req_in;
    end

    assign sel_ok = {1'b0, sel} < N_CH_W;
    assign req_g  = req_ext[g_q];

    // Walk downward so the lowest offset from rr_ptr is the last writer and wins.
    always_comb begin
        int j;
        j        = 0;
        pick_hit = 1'b0;
        pick_idx = '0;
        if (MODE == 0) begin
            pick_hit = sel_valid && sel_ok && req_ext[sel];
            pick_idx = sel;
        end else begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                j = int'(rr_ptr_q) + k;
                if (j >= N_CH) j = j - N_CH;
                if (req_ext[SEL_W'(j)]) begin
                    pick_hit = 1'b1;
                    pick_idx = SEL_W'(j);
                end
            end
        end
    end

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (SEL_W'(i) == pick_idx) pick_data = data_in[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            g_q       <= '0;
            rr_ptr_q  <= '0;
            data_q    <= '0;
            ack_out_q <= '0;
            req_out_q <= 1'b0;
            sel_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            rr_ptr_q  <= rr_ptr_d;
            data_q    <= data_d;
            ack_out_q <= ack_out_d;
            req_out_q <= req_out_d;
            sel_err_q <= sel_err_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_hit) state_d = FWD;
            FWD:     if (ack_in)   state_d = HOLD;
            HOLD:    if (!req_g)   state_d = DRAIN;
            DRAIN:   if (!ack_in)  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        g_d       = g_q;
        rr_ptr_d  = rr_ptr_q;
        data_d    = data_q;
        ack_out_d = ack_out_q;
        req_out_d = req_out_q;
        sel_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    g_d       = pick_idx;
                    data_d    = pick_data;
                    req_out_d = 1'b1;
                    if (MODE != 0) begin
                        rr_ptr_d = (pick_idx == SEL_W'(N_CH - 1)) ? '0 : pick_idx + 1'b1;
                    end
                end else if (MODE == 0 && sel_valid && !sel_ok) begin
                    sel_err_d = 1'b1;
                end
            end
            FWD:     if (ack_in)  ack_out_d = N_CH'(1) << g_q;
            HOLD:    if (!req_g)  req_out_d = 1'b0;
            DRAIN:   if (!ack_in) ack_out_d = '0;
            default: ;
        endcase
    end

    assign ack_out   = ack_out_q;
    assign req_out   = req_out_q;
    assign data_out  = data_q;
    assign grant_idx = g_q;
    assign busy      = busy_q;
    assign sel_err   = sel_err_q;

endmodule
